issue_scheduler: RTL

- Dual-issue scheduler between decode and the two execute lanes.
- Buffers decoded instructions in a small in-order queue and issues up to two per cycle into lane 0 and lane 1.
- Pairs two instructions only when they have no register hazard and neither is a jump.
- Drops all buffered and in-flight-to-execute work when either lane redirects the PC.

---
 rtl/issue_scheduler_pkg.sv | 18 +
 rtl/issue_pair_check.sv | 28 ++
 rtl/issue_scheduler.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/issue_scheduler_pkg.sv
// rtl/issue_scheduler_pkg.sv - shared control-bit positions, widths and defaults for the issue scheduler
package issue_scheduler_pkg;

  localparam int CTL_JR     = 0;
  localparam int CTL_JAL    = 1;
  localparam int CTL_WR     = 2;
  localparam int CTL_WIDTH  = 3;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_AWIDTH = 5;
  localparam int DEF_PWIDTH = 64;

  typedef logic [CTL_WIDTH-1:0] ctl_t;

  function automatic logic is_jump(input ctl_t c);
    return c[CTL_JR] | c[CTL_JAL];
  endfunction

endpackage

// File: rtl/issue_pair_check.sv
// rtl/issue_pair_check.sv - decides whether the two oldest queued instructions may issue together
module issue_pair_check
  import issue_scheduler_pkg::*;
#(
  parameter int AWIDTH = DEF_AWIDTH
) (
  input  logic [AWIDTH-1:0] rd0,
  input  logic [AWIDTH-1:0] rd1,
  input  logic [AWIDTH-1:0] rs1,
  input  logic [AWIDTH-1:0] rt1,
  input  ctl_t              ctl0,
  input  ctl_t              ctl1,
  output logic              pair_ok
);

  logic jump;
  logic raw;
  logic waw;

  // pairing is refused for jumps and for any RAW/WAW hazard on a non-zero destination
  always_comb begin
    jump    = is_jump(ctl0) | is_jump(ctl1);
    raw     = ctl0[CTL_WR] && (rd0 != '0) && ((rs1 == rd0) || (rt1 == rd0));
    waw     = ctl0[CTL_WR] && ctl1[CTL_WR] && (rd0 != '0) && (rd1 == rd0);
    pair_ok = !jump && !raw && !waw;
  end

endmodule

// File: rtl/issue_scheduler.sv
// rtl/issue_scheduler.sv - in-order queue feeding two execute lanes with hazard-aware dual issue
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int PWIDTH = DEF_PWIDTH
) (
  input  logic              is_clk,
  input  logic              is_rst,
  input  logic              is_i_vld0,
  input  logic              is_i_vld1,
  input  logic [AWIDTH-1:0] is_i_rd0,
  input  logic [AWIDTH-1:0] is_i_rd1,
  input  logic [AWIDTH-1:0] is_i_rs0,
  input  logic [AWIDTH-1:0] is_i_rt0,
  input  logic [AWIDTH-1:0] is_i_rs1,
  input  logic [AWIDTH-1:0] is_i_rt1,
  input  ctl_t              is_i_ctl0,
  input  ctl_t              is_i_ctl1,
  input  logic [PWIDTH-1:0] is_i_pay0,
  input  logic [PWIDTH-1:0] is_i_pay1,
  input  logic              is_i_stall,
  input  logic              is_i_flush,
  output logic              is_o_ready,
  output logic              is_o_ce0,
  output logic              is_o_ce1,
  output logic [AWIDTH-1:0] is_o_rd0,
  output logic [AWIDTH-1:0] is_o_rd1,
  output ctl_t              is_o_ctl0,
  output ctl_t              is_o_ctl1,
  output logic [PWIDTH-1:0] is_o_pay0,
  output logic [PWIDTH-1:0] is_o_pay1
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AWIDTH-1:0] rd_q  [DEPTH];
  logic [AWIDTH-1:0] rs_q  [DEPTH];
  logic [AWIDTH-1:0] rt_q  [DEPTH];
  ctl_t              ctl_q [DEPTH];
  logic [PWIDTH-1:0] pay_q [DEPTH];

  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] head1;
  logic [PW-1:0] wr_ptr1;
  logic          pair_ok;
  logic          iss0;
  logic          iss1;
  logic [CW-1:0] n_enq;
  logic [CW-1:0] n_iss;

  assign head1      = head_q + PW'(1);
  assign is_o_ready = (count_q <= CW'(DEPTH - 2));

  issue_pair_check #(.AWIDTH(AWIDTH)) u_pair (
    .rd0     (rd_q[head_q]),
    .rd1     (rd_q[head1]),
    .rs1     (rs_q[head1]),
    .rt1     (rt_q[head1]),
    .ctl0    (ctl_q[head_q]),
    .ctl1    (ctl_q[head1]),
    .pair_ok (pair_ok)
  );

  // issue decision and pointer increments; slot 1 lands right after slot 0 only when slot 0 is valid
  always_comb begin
    iss0    = !is_i_stall && (count_q != '0);
    iss1    = !is_i_stall && (count_q >= CW'(2)) && pair_ok;
    n_iss   = CW'(iss0) + CW'(iss1);
    n_enq   = CW'(is_i_vld0) + CW'(is_i_vld1);
    wr_ptr1 = tail_q + PW'(is_i_vld0);
  end

  // queue storage: compacted age-ordered write at tail, discarded while flushing
  always_ff @(posedge is_clk) begin
    if (!is_i_flush) begin
      if (is_i_vld0) begin
        rd_q[tail_q]  <= is_i_rd0;
        rs_q[tail_q]  <= is_i_rs0;
        rt_q[tail_q]  <= is_i_rt0;
        ctl_q[tail_q] <= is_i_ctl0;
        pay_q[tail_q] <= is_i_pay0;
      end
      if (is_i_vld1) begin
        rd_q[wr_ptr1]  <= is_i_rd1;
        rs_q[wr_ptr1]  <= is_i_rs1;
        rt_q[wr_ptr1]  <= is_i_rt1;
        ctl_q[wr_ptr1] <= is_i_ctl1;
        pay_q[wr_ptr1] <= is_i_pay1;
      end
    end
  end

  // head/tail/count bookkeeping; a redirect empties the queue
  always_ff @(posedge is_clk or posedge is_rst) begin
    if (is_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (is_i_flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PW'(n_iss);
      tail_q  <= tail_q + PW'(n_enq);
      count_q <= count_q + n_enq - n_iss;
    end
  end

  // lane output registers: hold on stall, kill valids on redirect, load data only for issued lanes
  always_ff @(posedge is_clk or posedge is_rst) begin
    if (is_rst) begin
      is_o_ce0  <= 1'b0;
      is_o_ce1  <= 1'b0;
      is_o_rd0  <= '0;
      is_o_rd1  <= '0;
      is_o_ctl0 <= '0;
      is_o_ctl1 <= '0;
      is_o_pay0 <= '0;
      is_o_pay1 <= '0;
    end else if (is_i_flush) begin
      is_o_ce0 <= 1'b0;
      is_o_ce1 <= 1'b0;
    end else if (!is_i_stall) begin
      is_o_ce0 <= iss0;
      is_o_ce1 <= iss1;
      if (iss0) begin
        is_o_rd0  <= rd_q[head_q];
        is_o_ctl0 <= ctl_q[head_q];
        is_o_pay0 <= pay_q[head_q];
      end
      if (iss1) begin
        is_o_rd1  <= rd_q[head1];
        is_o_ctl1 <= ctl_q[head1];
        is_o_pay1 <= pay_q[head1];
      end
    end
  end

endmodule
